mii_tx_reader: RTL and testbench

Read-side consumer of the byte FIFO on the Ethernet transmit path. On a start request it emits a frame as a 4-bit MII nibble stream: 7-byte preamble, SFD, then `frame_len` payload bytes pulled from the FIFO, each byte sent low nibble first, followed by a fixed inter-frame gap. A FIFO underrun mid-frame aborts the frame with `tx_er`, then discards the rest of that frame's bytes so the FIFO stays aligned to frame boundaries.

---
 rtl/mii_tx_reader.sv | 157 +++++++++++++++
 tb/tb_mii_tx_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_reader.sv
// Byte-FIFO consumer for the Ethernet TX path: emits preamble/SFD, payload
// nibbles (low first) and an inter-frame gap; aborts with tx_er on underrun.
module mii_tx_reader #(
  parameter int LEN_WIDTH   = 11,
  parameter int IFG_NIBBLES = 24
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  output logic                 ready,
  output logic                 done,
  output logic                 underrun,
  output logic                 fifo_read_en,
  input  logic [7:0]           fifo_data_out,
  input  logic                 fifo_empty,
  output logic [3:0]           txd,
  output logic                 tx_en,
  output logic                 tx_er
);

  localparam int CW = $clog2(IFG_NIBBLES + 16) + 1;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, ABORT, DRAIN, IFG} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [LEN_WIDTH-1:0] len_q, fetched_q, sent_q;
  logic [7:0]           hold_q, shift_q;
  logic                 hold_vld_q, rd_pend_q, nib_hi_q;
  logic [3:0]           txd_q;
  logic                 tx_en_q, tx_er_q, done_q, underrun_q;

  logic       boundary, more, byte_avail, sending;
  logic [7:0] next_byte;

  assign sending    = (state_q == PREAMBLE) || (state_q == DATA);
  assign boundary   = ((state_q == PREAMBLE) && (cnt_q == CW'(15))) ||
                      ((state_q == DATA) && nib_hi_q);
  assign more       = sent_q < len_q;
  // A read issued last cycle lands this cycle and can feed the shifter directly.
  assign byte_avail = hold_vld_q || rd_pend_q;
  assign next_byte  = hold_vld_q ? hold_q : fifo_data_out;

  assign fifo_read_en = (sending || (state_q == DRAIN)) && !hold_vld_q && !rd_pend_q &&
                        (fetched_q < len_q) && !fifo_empty;

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign underrun = underrun_q;
  assign txd      = txd_q;
  assign tx_en    = tx_en_q;
  assign tx_er    = tx_er_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      fetched_q  <= '0;
      sent_q     <= '0;
      hold_q     <= '0;
      shift_q    <= '0;
      hold_vld_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      nib_hi_q   <= 1'b0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      rd_pend_q  <= fifo_read_en;
      if (fifo_read_en) fetched_q <= fetched_q + LEN_WIDTH'(1);
      if (rd_pend_q && sending) begin
        hold_q     <= fifo_data_out;
        hold_vld_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (start && (frame_len != '0)) begin
            len_q      <= frame_len;
            fetched_q  <= '0;
            sent_q     <= '0;
            hold_vld_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= PREAMBLE;
            tx_en_q    <= 1'b1;
            txd_q      <= 4'h5;
          end
        end
        PREAMBLE: begin
          if (cnt_q != CW'(15)) begin
            cnt_q <= cnt_q + CW'(1);
            txd_q <= (cnt_q == CW'(14)) ? 4'hD : 4'h5;
          end
        end
        DATA: begin
          if (!nib_hi_q) begin
            txd_q    <= shift_q[7:4];
            nib_hi_q <= 1'b1;
          end else if (!more) begin
            state_q <= IFG;
            cnt_q   <= '0;
            tx_en_q <= 1'b0;
            txd_q   <= '0;
          end
        end
        ABORT: begin
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          txd_q   <= '0;
          cnt_q   <= '0;
          state_q <= (fetched_q == len_q) ? IFG : DRAIN;
        end
        DRAIN: begin
          if (fetched_q == len_q) begin
            state_q <= IFG;
            cnt_q   <= '0;
          end
        end
        IFG: begin
          if (cnt_q == CW'(IFG_NIBBLES - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // Byte boundary overrides the per-state updates above.
      if (boundary && more) begin
        hold_vld_q <= 1'b0;
        if (byte_avail) begin
          shift_q  <= next_byte;
          sent_q   <= sent_q + LEN_WIDTH'(1);
          txd_q    <= next_byte[3:0];
          nib_hi_q <= 1'b0;
          tx_en_q  <= 1'b1;
          state_q  <= DATA;
        end else begin
          txd_q      <= '0;
          tx_en_q    <= 1'b1;
          tx_er_q    <= 1'b1;
          underrun_q <= 1'b1;
          state_q    <= ABORT;
        end
      end
    end
  end

endmodule

// File: tb/tb_mii_tx_reader.sv
// Directed bench for mii_tx_reader with a behavioural byte FIFO and a
// negedge monitor that logs transmitted nibbles and control pulses.
module tb_mii_tx_reader;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [10:0] frame_len = '0;
  logic        ready, done, underrun, fifo_read_en, fifo_empty, tx_en, tx_er;
  logic [7:0]  fifo_data_out;
  logic [3:0]  txd;

  mii_tx_reader #(.LEN_WIDTH(11), .IFG_NIBBLES(24)) dut (
    .clk(clk), .resetN(resetN), .start(start), .frame_len(frame_len),
    .ready(ready), .done(done), .underrun(underrun), .fifo_read_en(fifo_read_en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .txd(txd), .tx_en(tx_en), .tx_er(tx_er)
  );

  always #5 clk = ~clk;

  // FIFO: registered read data, writes become visible after the next edge.
  logic [7:0] fq[$];
  logic [7:0] pq[$];
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fq.delete();
      fifo_data_out <= '0;
      fifo_empty    <= 1'b1;
    end else begin
      if (fifo_read_en && fq.size() > 0) fifo_data_out <= fq.pop_front();
      while (pq.size() > 0) fq.push_back(pq.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  int n_chk = 0, n_pass = 0;
  int ncyc = 0, s = 0;
  int en_cnt, rd_cnt, rd_noen, ur_cnt, ur_rel, done_cnt, done_rel, rise_rel, last_rd_rel, idle_bad;
  logic en_prev = 1'b0;
  logic [4:0] nibq[$];
  logic [4:0] expq[$];

  always @(negedge clk) begin
    ncyc++;
    if (tx_en) begin
      nibq.push_back({tx_er, txd});
      en_cnt++;
      if (!en_prev) rise_rel = ncyc - s;
    end
    en_prev = tx_en;
    if (!tx_en && (txd != 4'h0 || tx_er)) idle_bad++;
    if (fifo_read_en) begin
      rd_cnt++;
      last_rd_rel = ncyc - s;
      if (!tx_en) rd_noen++;
    end
    if (underrun) begin ur_cnt++; ur_rel = ncyc - s; end
    if (done) begin done_cnt++; done_rel = ncyc - s; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr_mon();
    nibq.delete(); expq.delete();
    en_cnt = 0; rd_cnt = 0; rd_noen = 0; ur_cnt = 0; ur_rel = -1;
    done_cnt = 0; done_rel = -1; rise_rel = -1; last_rd_rel = -1; idle_bad = 0;
  endtask

  task automatic exp_pre();
    repeat (15) expq.push_back(5'h05);
    expq.push_back(5'h0D);
  endtask

  task automatic exp_byte(input logic [7:0] b);
    expq.push_back({1'b0, b[3:0]});
    expq.push_back({1'b0, b[7:4]});
  endtask

  task automatic cmp_nibs(input string tag);
    int n;
    chk({tag, "_len"}, nibq.size(), expq.size());
    n = (nibq.size() < expq.size()) ? nibq.size() : expq.size();
    for (int i = 0; i < n; i++) chk(tag, {i[15:0], 11'd0, nibq[i]}, {i[15:0], 11'd0, expq[i]});
  endtask

  // Called just after a negedge; start is accepted at the following posedge.
  task automatic start_frame(input int len);
    s = ncyc;
    start = 1'b1;
    frame_len = 11'(len);
    @(posedge clk); #1;
    start = 1'b0;
    frame_len = '0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin @(negedge clk); #1; k++; end
    chk("done_seen", 32'(done_cnt >= target), 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin
    clr_mon();
    // Reset state
    step(3);
    chk("rst_txd", txd, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_er", tx_er, 0);
    chk("rst_rd_en", fifo_read_en, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", ready, 1);
    resetN = 1'b1;
    step(1);
    chk("ready_after_rst", ready, 1);

    // Basic frame
    clr_mon();
    pq.push_back(8'h12); pq.push_back(8'h34);
    step(2);
    start_frame(2);
    wait_done(1, 200);
    exp_pre(); exp_byte(8'h12); exp_byte(8'h34);
    cmp_nibs("basic_nib");
    chk("basic_en_cnt", en_cnt, 20);
    chk("basic_rd_cnt", rd_cnt, 2);
    chk("basic_done_rel", done_rel, 45);
    chk("basic_rise_rel", rise_rel, 1);
    chk("basic_no_ur", ur_cnt, 0);
    chk("basic_idle_bad", idle_bad, 0);

    // Underrun then drain
    clr_mon();
    pq.push_back(8'hAB);
    step(2);
    start_frame(3);
    for (int k = 0; k < 100 && ur_cnt == 0; k++) step(1);
    chk("ur_seen", ur_cnt, 1);
    chk("ur_rel", ur_rel, 19);
    step(10);
    pq.push_back(8'hC1); pq.push_back(8'hC2);
    wait_done(1, 200);
    exp_pre(); exp_byte(8'hAB); expq.push_back(5'h10);
    cmp_nibs("ur_nib");
    chk("ur_rd_cnt", rd_cnt, 3);
    chk("ur_drain_reads", rd_noen, 2);
    chk("ur_gap", done_rel - last_rd_rel, 26);
    chk("ur_fifo_empty", fq.size() + pq.size(), 0);
    chk("ur_idle_bad", idle_bad, 0);

    // Zero-length start ignored
    clr_mon();
    start_frame(0);
    step(40);
    chk("zl_en", en_cnt, 0);
    chk("zl_rd", rd_cnt, 0);
    chk("zl_done", done_cnt, 0);
    chk("zl_ready", ready, 1);

    // Start mid-DATA ignored
    clr_mon();
    for (int i = 0; i < 4; i++) pq.push_back(8'hA0 + 8'(i));
    step(2);
    start_frame(4);
    while (ncyc - s < 20) step(1);
    start = 1'b1; frame_len = 11'd2;
    @(posedge clk); #1;
    start = 1'b0; frame_len = '0;
    wait_done(1, 200);
    exp_pre(); for (int i = 0; i < 4; i++) exp_byte(8'hA0 + 8'(i));
    cmp_nibs("mid_nib");
    chk("mid_done_rel", done_rel, 49);
    step(40);
    chk("mid_en_cnt", en_cnt, 24);
    chk("mid_done_cnt", done_cnt, 1);
    chk("mid_rd_cnt", rd_cnt, 4);

    // Reset during DATA byte 5
    clr_mon();
    for (int i = 0; i < 8; i++) pq.push_back(8'h70 + 8'(i));
    step(2);
    start_frame(8);
    while (ncyc - s < 25) step(1);
    chk("pre_rst_tx_en", tx_en, 1);
    resetN = 1'b0;
    #1;
    chk("mrst_tx_en", tx_en, 0);
    chk("mrst_txd", txd, 0);
    chk("mrst_rd_en", fifo_read_en, 0);
    chk("mrst_ready", ready, 1);
    step(2);
    resetN = 1'b1;
    clr_mon();
    pq.push_back(8'h01);
    step(2);
    start_frame(1);
    wait_done(1, 200);
    exp_pre(); exp_byte(8'h01);
    cmp_nibs("post_rst_nib");
    chk("post_rst_done_rel", done_rel, 43);

    // Back-to-back frames
    clr_mon();
    for (int i = 0; i < 60; i++) pq.push_back(8'(i));
    step(2);
    start_frame(30);
    wait_done(1, 300);
    start_frame(30);
    wait_done(2, 300);
    exp_pre(); for (int i = 0; i < 30; i++) exp_byte(8'(i));
    exp_pre(); for (int i = 30; i < 60; i++) exp_byte(8'(i));
    cmp_nibs("b2b_nib");
    chk("b2b_rise_rel", rise_rel, 1);
    chk("b2b_done_rel", done_rel, 101);
    chk("b2b_ur", ur_cnt, 0);
    chk("b2b_rd_cnt", rd_cnt, 60);
    chk("b2b_idle_bad", idle_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
